// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: active-low segment codes,
// slot index width and the scan state encoding.
package seg_pkg;

    localparam int SLOT_W = 2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9
    localparam logic [6:0] SEG_CODE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    // Bit k set when slot k and every slot to its left hold zero; slot 3 never blanks.
    function automatic logic [3:0] lead_zero_mask(input logic [15:0] d);
        logic [3:0] m;
        m[0] = (d[15:12] == 4'd0);
        m[1] = m[0] & (d[11:8] == 4'd0);
        m[2] = m[1] & (d[7:4] == 4'd0);
        m[3] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Digit source / display bus of the scan driver; master is the upstream
// digit mux and controls, slave is the driver itself.
interface seg_scan_driver_if;

    logic [15:0] digits_in;
    logic        page_auto;
    logic        page_next;
    logic        blank_lead;
    logic [3:0]  dp_mask;
    logic [1:0]  page_sel;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (
        output digits_in, page_auto, page_next, blank_lead, dp_mask,
        input  page_sel, an, seg, dp, frame_tick
    );

    modport slave (
        input  digits_in, page_auto, page_next, blank_lead, dp_mask,
        output page_sel, an, seg, dp, frame_tick
    );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 are blank.
module bcd_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd < 4'd10) seg = SEG_CODE[bcd];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with page selection, leading-zero
// blanking and per-slot dead time.
//
// state   | meaning
// ST_WAIT | first prescaler period after reset; display dark, no slot active
// ST_SCAN | cycling through slots 0..3, one prescaler period each
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int DEAD      = 4,
    parameter int PAGE_HOLD = 500
) (
    input logic              clk,
    input logic              rst_n,
    seg_scan_driver_if.slave bus
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (PAGE_HOLD > 1) ? $clog2(PAGE_HOLD) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] DEAD_LAST  = PW'(DEAD - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(PAGE_HOLD - 1);

    logic [PW-1:0]     presc;
    logic              slot_tick;
    scan_state_t       state, state_nxt;
    logic [SLOT_W-1:0] slot, slot_nxt;
    logic              enter_slot0, enter_slot3;

    logic [15:0]       snap, snap_nxt;
    logic [3:0]        digit;
    logic [3:0]        lz_mask;
    logic              lead_blank;
    logic [6:0]        seg_dec, seg_d;
    logic              dp_d;

    logic [1:0]        page_sel_q;
    logic              pending;
    logic [FW-1:0]     frame_cnt;
    logic              auto_req, advance;

    logic [3:0]        an_q;
    logic [6:0]        seg_q;
    logic              dp_q;
    logic              ft_q;

    assign slot_tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (slot_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT;
            slot  <= '0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
        end
    end

    // The first tick after reset enters slot 0 without advancing the index.
    always_comb begin
        state_nxt   = state;
        slot_nxt    = slot;
        enter_slot0 = 1'b0;
        enter_slot3 = 1'b0;
        if (slot_tick) begin
            case (state)
                ST_WAIT: begin
                    state_nxt   = ST_SCAN;
                    enter_slot0 = 1'b1;
                end
                ST_SCAN: begin
                    slot_nxt    = slot + 1'b1;
                    enter_slot0 = (&slot);
                    enter_slot3 = (slot == SLOT_W'(2));
                end
                default: state_nxt = ST_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
        end else begin
            snap <= snap_nxt;
        end
    end

    assign snap_nxt = enter_slot0 ? bus.digits_in : snap;

    // Decode the digit the next slot will show so seg/dp switch with the slot.
    always_comb begin
        case (slot_nxt)
            2'd1:    digit = snap_nxt[11:8];
            2'd2:    digit = snap_nxt[7:4];
            2'd3:    digit = snap_nxt[3:0];
            default: digit = snap_nxt[15:12];
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (digit),
        .seg (seg_dec)
    );

    assign lz_mask    = lead_zero_mask(snap_nxt);
    assign lead_blank = bus.blank_lead & lz_mask[slot_nxt];
    assign seg_d      = lead_blank ? SEG_BLANK : seg_dec;
    // For a 2-bit slot, ~slot_nxt is 3 - slot_nxt (bit 3 is the leftmost digit).
    assign dp_d       = ~bus.dp_mask[~slot_nxt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            ft_q  <= 1'b0;
        end else begin
            ft_q <= enter_slot0;
            if (slot_tick) begin
                an_q <= 4'b1111;
            end else if (state == ST_SCAN && presc == DEAD_LAST) begin
                an_q <= ~(4'b1000 >> slot);
            end
            if (slot_tick) begin
                seg_q <= seg_d;
                dp_q  <= dp_d;
            end
        end
    end

    // Page changes only when entering slot 3, a full slot ahead of the snapshot.
    assign auto_req = bus.page_auto && (frame_cnt == FRAME_LAST);
    assign advance  = enter_slot3 && (pending || bus.page_next || auto_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            page_sel_q <= 2'd0;
            frame_cnt  <= '0;
        end else begin
            if (enter_slot3) begin
                pending <= 1'b0;
            end else if (bus.page_next) begin
                pending <= 1'b1;
            end

            if (advance) begin
                page_sel_q <= page_sel_q + 2'd1;
            end

            if (!bus.page_auto || advance) begin
                frame_cnt <= '0;
            end else if (enter_slot3) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = ft_q;
    assign bus.page_sel   = page_sel_q;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per digit slot (min 4).
REQ-002 Parameter DEAD, default 4, cycles per slot with all anodes off (1 <= DEAD < SCAN_DIV).
REQ-003 Parameter PAGE_HOLD, default 500, scan frames per page in auto mode (min 1).
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 digits_in  in  16  four BCD digits of the selected page; [15:12] is the leftmost digit.
REQ-007 page_auto  in  1  1 = advance page every PAGE_HOLD frames.
REQ-008 page_next  in  1  single-cycle pulse requesting a page advance; already debounced.
REQ-009 blank_lead  in  1  1 = leading-zero blanking enabled.
REQ-010 dp_mask  in  4  decimal point enable per digit, bit 3 = leftmost.
REQ-011 page_sel  out  2  registered page select that drives the upstream digit mux.
REQ-012 an  out  4  anode enables, active-low, bit 3 = leftmost.
REQ-013 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-014 dp  out  1  decimal point, active-low.
REQ-015 frame_tick  out  1  one-cycle pulse at the start of each frame (slot 0 entry).

Function
REQ-016 Prescaler counts 0..SCAN_DIV-1 and wraps; slot_tick asserts in the cycle the count is SCAN_DIV-1.
REQ-017 Slot index 0..3 advances on slot_tick and wraps 3->0; slot 0 = leftmost digit, an[3].
REQ-018 On the slot_tick that enters slot 0, snapshot <= digits_in, and frame_tick asserts in the following cycle.
REQ-019 page_sel changes only on the slot_tick that enters slot 3, so that the mux output is stable for SCAN_DIV cycles before the snapshot.
REQ-020 Page advance = page_sel + 1 mod 4; 3 wraps to 0.
REQ-021 page_next sets a pending flag; the pending flag is consumed at the next page-update point (REQ-019).
REQ-022 Auto mode: frame counter counts to PAGE_HOLD-1 and then requests an advance at the next update point; the counter clears on every advance.
REQ-023 Pending flag and auto request in the same update point -> exactly one advance.
REQ-024 A page_next pulse while the pending flag is already set has no additional effect.
REQ-025 When page_auto=0, the frame counter holds at 0; a manual advance still clears it.
REQ-026 For the first DEAD cycles of each slot, an = 4'b1111; for the remaining cycles of the slot, only the active slot's anode bit is 0.
REQ-027 seg and dp are registered from the snapshot digit of the current slot and update on the cycle the slot changes.
REQ-028 A digit value of 10..15 displays blank (seg = 7'h7F).
REQ-029 With blank_lead=1, slot k<3 is blank when it and all slots to its left are 0; slot 3 is never blanked by this rule.
REQ-030 dp = ~dp_mask[3-slot], independent of blanking.
REQ-031 All outputs are registered; nothing combinational runs from the inputs to the outputs.

Reset
REQ-032 Reset asserted, asynchronously, drives: an=4'b1111, seg=7'h7F, dp=1, frame_tick=0, page_sel=0.
REQ-033 Reset also clears internal state: prescaler=0, slot=0, snapshot=0, pending=0, frame counter=0.
REQ-034 After reset deassertion, the first slot_tick occurs SCAN_DIV cycles later; there is no partial frame.
REQ-035 Reset mid-frame or mid-pending discards the pending request; the display is dark until the first active slot after DEAD.

Structure
REQ-036 Shared package seg_pkg holds:
- segment encodings for 0-9;
- the SEG_BLANK constant (7'h7F);
- the slot index width.
REQ-037 One combinational sub-module, bcd_to_seg7 (4-bit in, 7-bit active-low out, blank for >9), is instantiated once.
REQ-038 The scan, page and blanking logic stays in seg_scan_driver; the target size is 150-300 lines.

Verification (SCAN_DIV=8, DEAD=2, PAGE_HOLD=3)
REQ-039 Reset release, digits_in=16'h1234 -> an sequence:
- 1111 for the first 8 cycles;
- 0111 for cycles 3-8 of slot 0, with seg=1's code;
- 1011/2, 1101/3, 1110/4 in the following slots.
REQ-040 page_auto=1, page_next=0 -> page_sel steps 0,1,2,3,0, changing only on the slot-3 entry of every 3rd frame.
REQ-041 page_next pulse during slot 0 -> page_sel+1 at the same frame's slot-3 entry.
- Two pulses within one frame -> a single advance.
REQ-042 digits_in changed during slots 1-3 -> displayed digits unchanged until the next frame.
REQ-043 blank_lead=1, digits_in=16'h0040 -> slots 0,1 blank, slot 2 '4', slot 3 '0'.
- digits_in=16'h00A5 -> slot 2 blank by the invalid-code rule (REQ-028).
REQ-044 rst_n low in mid-slot with pending set -> outputs go to reset values within the same cycle, and there is no page advance after release.
